// File: rtl/gf_pkg.sv
// Shared types and constants for the GF(2^m) sequential reducer.
package gf_pkg;

    // Controller states of the reducer.
    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        DONE
    } state_t;

    // AES field polynomial x^8 + x^4 + x^3 + x + 1, with the x^8 term implicit.
    localparam logic [7:0] GF_POLY_AES = 8'h1B;

endpackage

// File: rtl/gf_reduce_seq_if.sv
// Operand/result handshake bundle between the upstream multiplier, the
// reducer and its consumer.
interface gf_reduce_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [2*DATA_WIDTH-1:0]   in_prod;
    logic [DATA_WIDTH-1:0]     in_poly;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_rem;

    // Producer/consumer side: supplies operands and accepts results.
    modport master (
        output in_valid, in_prod, in_poly, out_ready,
        input  in_ready, out_valid, out_rem
    );

    // Reducer side.
    modport slave (
        input  in_valid, in_prod, in_poly, out_ready,
        output in_ready, out_valid, out_rem
    );
endinterface

// File: rtl/gf_reduce_step.sv
// One conditional cancellation step of GF(2) polynomial long division:
// if bit k of the work value is set, XOR in the full modulus aligned to k.
module gf_reduce_step #(
    parameter  int DATA_WIDTH = 32,
    localparam int KW         = $clog2(2*DATA_WIDTH)
) (
    input  logic [2*DATA_WIDTH-1:0] w,
    input  logic [DATA_WIDTH-1:0]   p,
    input  logic [KW-1:0]           k,
    output logic [2*DATA_WIDTH-1:0] w_next
);

    logic [2*DATA_WIDTH-1:0] poly_ext;
    logic [KW-1:0]           shift;

    // Place the implicit leading 1 of {1,P} on bit k so the XOR clears it.
    always_comb begin
        poly_ext = {{(DATA_WIDTH-1){1'b0}}, 1'b1, p};
        shift    = k - KW'(DATA_WIDTH);
        w_next   = w[k] ? (w ^ (poly_ext << shift)) : w;
    end

endmodule

// File: rtl/gf_reduce_seq.sv
// Sequential GF(2^m) reducer: takes a 2m-bit carry-less product and returns
// it modulo x^m + poly, one bit position per cycle over m cycles.
module gf_reduce_seq
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    gf_reduce_seq_if.slave bus
);

    localparam int            KW      = $clog2(2*DATA_WIDTH);
    localparam logic [KW-1:0] K_START = KW'(2*DATA_WIDTH-1);
    localparam logic [KW-1:0] K_LAST  = KW'(DATA_WIDTH);

    state_t                  state;
    state_t                  state_next;
    logic [2*DATA_WIDTH-1:0] w;
    logic [2*DATA_WIDTH-1:0] w_step;
    logic [DATA_WIDTH-1:0]   p;
    logic [KW-1:0]           k;

    gf_reduce_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .w      (w),
        .p      (p),
        .k      (k),
        .w_next (w_step)
    );

    // Next-state and handshake decode; ready/valid follow the state directly.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = REDUCE;
            end
            REDUCE: begin
                if (k == K_LAST) state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The low half of W is the remainder once all upper bits are cancelled.
    assign bus.out_rem = w[DATA_WIDTH-1:0];

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Datapath: load on accept, one cancellation step per REDUCE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            w <= '0;
            p <= '0;
            k <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        w <= bus.in_prod;
                        p <= bus.in_poly;
                        k <= K_START;
                    end
                end
                REDUCE: begin
                    w <= w_step;
                    k <= k - KW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_reduce_seq.sv
// Self-checking bench for gf_reduce_seq at DATA_WIDTH=8.
module tb_gf_reduce_seq;
    import gf_pkg::*;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gf_reduce_seq_if #(.DATA_WIDTH(DW)) bus ();

    gf_reduce_seq #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: sum of x^i mod (x^m + poly) over the set bits of prod,
    // with x^i built by repeated multiply-by-x in the field.
    function automatic logic [DW-1:0] gf_mod(input logic [2*DW-1:0] prod, input logic [DW-1:0] poly);
        logic [DW-1:0] rem;
        logic [DW-1:0] pw;
        rem = '0;
        pw  = DW'(1);
        for (int i = 0; i < 2*DW; i++) begin
            if (prod[i]) rem ^= pw;
            pw = pw[DW-1] ? ((pw << 1) ^ poly) : (pw << 1);
        end
        return rem;
    endfunction

    // Scoreboard and per-cycle compare process
    logic [DW-1:0] exp_q[$];
    int unsigned   cyc = 0;
    int unsigned   acc_cyc;
    bit            lat_pending = 0;
    bit            prev_ov = 0;
    bit            prev_hs = 0;
    logic [DW-1:0] prev_rem;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            lat_pending = 0;
            prev_ov     = 0;
            prev_hs     = 0;
        end else begin
            if (bus.out_valid && prev_ov && !prev_hs)
                check("stall_rem_stable", bus.out_rem, prev_rem);
            if (bus.out_valid) check("ready_low_in_done", bus.in_ready, 1'b0);
            if (bus.out_valid && lat_pending) begin
                check("latency", cyc - acc_cyc, DW + 1);
                lat_pending = 0;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(gf_mod(bus.in_prod, bus.in_poly));
                acc_cyc     = cyc;
                lat_pending = 1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_output: got %0h expected none", bus.out_rem);
                end else begin
                    check("stream_rem", bus.out_rem, exp_q.pop_front());
                end
            end
            prev_ov  = bus.out_valid;
            prev_hs  = bus.out_valid && bus.out_ready;
            prev_rem = bus.out_rem;
        end
    end

    // Wait (bounded) for the DUT to be ready, then let the accept edge pass.
    task automatic wait_accept(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_accept_timeout"}, n < 50, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_timeout"}, n < 50, 1'b1);
    endtask

    task automatic run_op(input string name, input logic [2*DW-1:0] prod,
                          input logic [DW-1:0] poly, input logic [DW-1:0] exp);
        bus.in_prod  = prod;
        bus.in_poly  = poly;
        bus.in_valid = 1'b1;
        wait_accept(name);
        bus.in_valid = 1'b0;
        wait_out_valid(name);
        check(name, bus.out_rem, exp);
        @(posedge clk);
        #1;
    endtask

    bit stream_done = 0;

    initial begin
        int n;
        bit acc;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.in_poly   = '0;
        bus.out_ready = 1'b1;

        // Model pinned against hand-computed values
        check("model_aes_c1", gf_mod(16'h2B79, GF_POLY_AES), 8'hC1);
        check("model_x14",    gf_mod(16'h4000, GF_POLY_AES), 8'h9A);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_rem",   bus.out_rem,   8'h00);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors
        run_op("aes_57x83",  16'h2B79, GF_POLY_AES, 8'hC1);
        run_op("x8",         16'h0100, GF_POLY_AES, 8'h1B);
        run_op("x14",        16'h4000, GF_POLY_AES, 8'h9A);
        run_op("upper_zero", 16'h00FF, GF_POLY_AES, 8'hFF);
        run_op("poly_zero",  16'hABCD, 8'h00,       8'hCD);
        run_op("top_bit",    16'h8000, GF_POLY_AES, 8'h2F);

        // Back-pressure in DONE; input changes mid-operation are ignored
        bus.out_ready = 1'b0;
        bus.in_prod   = 16'h0100;
        bus.in_poly   = GF_POLY_AES;
        bus.in_valid  = 1'b1;
        wait_accept("stall");
        bus.in_prod   = 16'h4000;
        wait_out_valid("stall");
        check("stall_first_rem", bus.out_rem, 8'h1B);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", bus.out_valid, 1'b1);
            check("stall_rem",       bus.out_rem,   8'h1B);
            check("stall_in_ready",  bus.in_ready,  1'b0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready",  bus.in_ready,  1'b1);
        check("release_out_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("next_accepted", bus.in_ready, 1'b0);
        wait_out_valid("after_stall");
        check("after_stall_rem", bus.out_rem, 8'h9A);
        @(posedge clk);
        #1;

        // Reset in the middle of REDUCE aborts without output
        bus.in_prod  = 16'h2B79;
        bus.in_poly  = GF_POLY_AES;
        bus.in_valid = 1'b1;
        wait_accept("abort");
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready",  bus.in_ready,  1'b1);
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_out_rem",   bus.out_rem,   8'h00);
        @(posedge clk);
        #1;
        run_op("post_abort", 16'h2B79, GF_POLY_AES, 8'hC1);

        // Back-to-back stream with random consumer stalls
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    bus.in_prod  = 16'($urandom);
                    bus.in_poly  = (i % 4 == 0) ? 8'($urandom) : GF_POLY_AES;
                    bus.in_valid = 1'b1;
                    n   = 0;
                    acc = 0;
                    while (!acc && n < 100) begin
                        @(negedge clk);
                        acc = bus.in_ready;
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    if (!acc) check("stream_accept_timeout", n, 0);
                end
                bus.in_valid = 1'b0;
                stream_done  = 1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gf_reduce_seq.md
GF_REDUCE_SEQ -- requirements
Module: gf_reduce_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32: field degree m, equal to the width of the carry-less multiplier operands.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_prod and in_poly are valid.
REQ-005 in_ready  output  1  block accepts an operand this cycle.
REQ-006 in_prod  input  2*DATA_WIDTH  raw carry-less product from the upstream multiplier.
REQ-007 in_poly  input  DATA_WIDTH  coefficients x^(m-1)..x^0 of the irreducible polynomial; the x^m term is implicit 1.
REQ-008 out_valid  output  1  out_rem holds a completed remainder.
REQ-009 out_ready  input  1  downstream consumes out_rem.
REQ-010 out_rem  output  DATA_WIDTH  in_prod mod (x^m + in_poly) over GF(2).

Function
REQ-011 States SHALL be IDLE, REDUCE and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-012 Accept SHALL occur when in_valid and in_ready are both high at a clock edge: latch in_prod into work register W (2*DATA_WIDTH bits), latch in_poly into P, load bit index k = 2*DATA_WIDTH-1, and go to REDUCE.
REQ-013 In each REDUCE cycle: if W[k]=1, W SHALL become W XOR ({1,P} << (k-DATA_WIDTH)); k SHALL then decrement by 1.
REQ-014 REDUCE SHALL last exactly DATA_WIDTH cycles (k = 2m-1 down to m), independent of data; after the cycle with k=m, go to DONE.
REQ-015 In DONE, out_rem SHALL equal W[DATA_WIDTH-1:0] and SHALL stay stable until out_valid and out_ready are both high; then go to IDLE.
REQ-016 Latency from accept edge to out_valid high SHALL be DATA_WIDTH+1 cycles; throughput SHALL be one result per DATA_WIDTH+2 cycles, with no same-cycle accept on the DONE exit.
REQ-017 Input changes while not in IDLE SHALL be ignored; in_valid in REDUCE or DONE SHALL NOT cause an accept.
REQ-018 An input with in_prod[2m-1:m]=0 SHALL still take the full latency and SHALL return in_prod[m-1:0].
REQ-019 in_poly=0 SHALL be legal (reduction by x^m) and SHALL return in_prod[m-1:0].
REQ-020 in_prod[2m-1]=1 (not produced by the multiplier) SHALL be reduced correctly, not truncated.
REQ-021 out_valid held with out_ready low SHALL hold DONE indefinitely with no change to out_rem.
REQ-022 The bit-index counter SHALL be $clog2(2*DATA_WIDTH) bits wide and SHALL never wrap during REDUCE.

Reset
REQ-023 rst at any clock edge, including mid-REDUCE or in DONE, SHALL force IDLE and abort the operation with no output produced.
REQ-024 Reset values SHALL be: in_ready=1 and out_valid=0 from the first cycle after reset; W, P, k and out_rem all 0.
REQ-025 rst SHALL take priority over accept and over the out handshake in the same cycle.

Structure
REQ-026 Shared package gf_pkg SHALL hold the state enum type and the constant GF_POLY_AES = 8'h1B used by benches.
REQ-027 The one-bit conditional XOR step of REQ-013 SHALL be a combinational sub-module gf_reduce_step, parameterised by DATA_WIDTH, taking W, P and k and returning the next W.
REQ-028 No multiplication SHALL be inferred; only XOR, shift and mux logic.

Verification (DATA_WIDTH=8, in_poly=8'h1B unless stated)
REQ-029 in_prod=16'h2B79 (clmul 0x57,0x83) -> out_rem=8'hC1 with out_valid first high 9 cycles after accept.
REQ-030 in_prod=16'h0100 -> 8'h1B; in_prod=16'h4000 -> 8'h9A; in_prod=16'h00FF -> 8'hFF after the full latency.
REQ-031 in_poly=8'h00, in_prod=16'hABCD -> 8'hCD.
REQ-032 out_ready low for 5 cycles in DONE -> out_valid and out_rem stable, in_ready low, and a new in_valid is ignored; release -> IDLE and next operand accepted on the following edge.
REQ-033 rst asserted on REDUCE cycle 4 -> next cycle IDLE, in_ready=1, out_valid=0, out_rem=0; a subsequent operand reduces correctly.
REQ-034 Random back-to-back stream of 1000 operands with random out_ready stalls -> every out_rem matches a reference model, in order, none dropped or duplicated.
